// File: rtl/pio_cmd_decoder_if.sv
// ---------------------------------------------------------------------------
// pio_cmd_if : PIO host command bus.
//
// One command per clock from a loader/CPU (master) to the command decoder
// (slave). There is no handshake: a non-zero action is a command and is
// always accepted.
//
// Signals:
//   action  [3:0]        command code, 0 = idle           (master -> slave)
//   index   [IDX_W-1:0]  instruction memory address        (master -> slave)
//   mindex  [SM_W-1:0]   target state machine              (master -> slave)
//   din     [31:0]       command payload                   (master -> slave)
//   dout    [31:0]       read data                         (slave -> master)
// ---------------------------------------------------------------------------
interface pio_cmd_if #(
  parameter int NUM_SM     = 4,
  parameter int IMEM_DEPTH = 32
);
  localparam int SM_W  = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;
  localparam int IDX_W = $clog2(IMEM_DEPTH);

  logic [3:0]       action;
  logic [IDX_W-1:0] index;
  logic [SM_W-1:0]  mindex;
  logic [31:0]      din;
  logic [31:0]      dout;

  modport master (output action, output index, output mindex, output din, input dout);
  modport slave  (input action, input index, input mindex, input din, output dout);
endinterface

// File: rtl/pio_cmd_decoder.sv
// ---------------------------------------------------------------------------
// pio_cmd_decoder : responder end of the PIO host command bus.
//
// Owns the shared instruction memory and the per-machine configuration
// registers, emits one-cycle TX-push / RX-pop / restart strobes and returns
// RX data on dout.
//
// Ports:
//   clk            system clock, all logic on posedge
//   reset          synchronous, active-high
//   bus            pio_cmd_if.slave (action, index, mindex, din, dout)
//   pc_flat        per-machine fetch address, IDX_W bits each
//   instr_flat     per-machine fetched instruction (combinational imem read)
//   en             machine enable mask
//   restart        one-cycle restart strobe per machine
//   div_int_flat   16-bit integer clock divider per machine
//   div_frac_flat  8-bit fractional clock divider per machine
//   wrap_top_flat  wrap address per machine
//   wrap_tgt_flat  wrap target per machine
//   pins_flat      32-bit pin-group word per machine
//   sideset_flat   5-bit sideset config per machine ([2:0] count, [3] opt, [4] pindirs)
//   tx_push        one-cycle TX FIFO push strobe per machine
//   tx_data        registered TX push data
//   rx_pop         one-cycle RX FIFO pop strobe per machine
//   rx_data_flat   RX FIFO head word per machine
//
// Build option:
//   PIO_READBACK_EN  when defined, action 10 loads dout with a configuration
//                    word for machine mindex chosen by din[2:0]; otherwise
//                    action 10 is ignored and no readback mux exists.
// ---------------------------------------------------------------------------
module pio_cmd_decoder #(
  parameter int          NUM_SM     = 4,
  parameter int          IMEM_DEPTH = 32,
  parameter logic [15:0] DIV_RESET  = 16'h0001,
  localparam int         SM_W       = (NUM_SM > 1) ? $clog2(NUM_SM) : 1,
  localparam int         IDX_W      = $clog2(IMEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  pio_cmd_if.slave                bus,
  input  logic [NUM_SM*IDX_W-1:0] pc_flat,
  output logic [NUM_SM*16-1:0]    instr_flat,
  output logic [NUM_SM-1:0]       en,
  output logic [NUM_SM-1:0]       restart,
  output logic [NUM_SM*16-1:0]    div_int_flat,
  output logic [NUM_SM*8-1:0]     div_frac_flat,
  output logic [NUM_SM*IDX_W-1:0] wrap_top_flat,
  output logic [NUM_SM*IDX_W-1:0] wrap_tgt_flat,
  output logic [NUM_SM*32-1:0]    pins_flat,
  output logic [NUM_SM*5-1:0]     sideset_flat,
  output logic [NUM_SM-1:0]       tx_push,
  output logic [31:0]             tx_data,
  output logic [NUM_SM-1:0]       rx_pop,
  input  logic [NUM_SM*32-1:0]    rx_data_flat
);

  localparam logic [3:0] ACT_IMEM    = 4'd1;
  localparam logic [3:0] ACT_WRAP    = 4'd2;
  localparam logic [3:0] ACT_TX      = 4'd3;
  localparam logic [3:0] ACT_RX      = 4'd4;
  localparam logic [3:0] ACT_PINS    = 4'd5;
  localparam logic [3:0] ACT_EN      = 4'd6;
  localparam logic [3:0] ACT_DIV     = 4'd7;
  localparam logic [3:0] ACT_SIDESET = 4'd8;
  localparam logic [3:0] ACT_RESTART = 4'd9;

  // One-hot select of a single machine, used for the per-machine strobes.
  function automatic logic [NUM_SM-1:0] sm_onehot(input logic [SM_W-1:0] m);
    logic [NUM_SM-1:0] oh;
    oh    = {NUM_SM{1'b0}};
    oh[m] = 1'b1;
    return oh;
  endfunction

  // Instruction memory: no reset, written only by action 1.
  logic [15:0]       imem_r [IMEM_DEPTH];

  logic [NUM_SM-1:0] en_r;
  logic [NUM_SM-1:0] restart_r;
  logic [NUM_SM-1:0] tx_push_r;
  logic [NUM_SM-1:0] rx_pop_r;
  logic [31:0]       tx_data_r;
  logic [31:0]       dout_r;
  logic [15:0]       div_int_r  [NUM_SM];
  logic [7:0]        div_frac_r [NUM_SM];
  logic [IDX_W-1:0]  wrap_top_r [NUM_SM];
  logic [IDX_W-1:0]  wrap_tgt_r [NUM_SM];
  logic [31:0]       pins_r     [NUM_SM];
  logic [4:0]        sideset_r  [NUM_SM];
  logic [31:0]       rx_data_s  [NUM_SM];

`ifdef PIO_READBACK_EN
  localparam logic [3:0] ACT_READBACK = 4'd10;

  logic [31:0] readback_s;

  // Configuration readback word for the addressed machine.
  always_comb begin
    readback_s = 32'h0000_0000;
    case (bus.din[2:0])
      // Packed summary; the divider's low 5 bits are dropped to make it fit.
      3'd0: readback_s = {{(32-2*IDX_W-11){1'b0}}, wrap_tgt_r[bus.mindex],
                          wrap_top_r[bus.mindex], div_int_r[bus.mindex][15:5]};
      3'd1: readback_s = {8'h00, div_int_r[bus.mindex], div_frac_r[bus.mindex]};
      3'd2: readback_s = pins_r[bus.mindex];
      3'd3: readback_s = {27'h000_0000, sideset_r[bus.mindex]};
      3'd4: readback_s = {16'h0000, imem_r[bus.index]};
      default: readback_s = 32'h0000_0000;
    endcase
  end
`endif

  // Instruction memory write port. The fetch ports read the array directly,
  // so a same-cycle fetch of the written address still sees the old word.
  always_ff @(posedge clk) begin
    if (!reset && (bus.action == ACT_IMEM)) begin
      imem_r[bus.index] <= bus.din[15:0];
    end
  end

  // Command decode: configuration registers, strobes and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_r      <= {NUM_SM{1'b0}};
      restart_r <= {NUM_SM{1'b0}};
      tx_push_r <= {NUM_SM{1'b0}};
      rx_pop_r  <= {NUM_SM{1'b0}};
      tx_data_r <= 32'h0000_0000;
      dout_r    <= 32'h0000_0000;
      for (int m = 0; m < NUM_SM; m++) begin
        div_int_r[m]  <= DIV_RESET;
        div_frac_r[m] <= 8'h00;
        wrap_top_r[m] <= IDX_W'(IMEM_DEPTH - 1);
        wrap_tgt_r[m] <= {IDX_W{1'b0}};
        pins_r[m]     <= 32'h0000_0000;
        sideset_r[m]  <= 5'h00;
      end
    end else begin
      // Strobes fall back to zero unless this cycle's command re-asserts
      // them, so back-to-back commands give back-to-back pulses.
      tx_push_r <= {NUM_SM{1'b0}};
      rx_pop_r  <= {NUM_SM{1'b0}};
      restart_r <= {NUM_SM{1'b0}};
      case (bus.action)
        ACT_WRAP: begin
          wrap_top_r[bus.mindex] <= bus.din[IDX_W-1:0];
          wrap_tgt_r[bus.mindex] <= bus.din[2*IDX_W-1:IDX_W];
        end
        ACT_TX: begin
          tx_data_r <= bus.din;
          tx_push_r <= sm_onehot(bus.mindex);
        end
        ACT_RX: begin
          // FIFO head is captured in the accept cycle, before the pop lands.
          dout_r   <= rx_data_s[bus.mindex];
          rx_pop_r <= sm_onehot(bus.mindex);
        end
        ACT_PINS:    pins_r[bus.mindex] <= bus.din;
        ACT_EN:      en_r <= bus.din[NUM_SM-1:0];
        ACT_DIV: begin
          // An integer part of 0 is kept as 0; the machines read it as 65536.
          div_int_r[bus.mindex]  <= bus.din[23:8];
          div_frac_r[bus.mindex] <= bus.din[7:0];
        end
        ACT_SIDESET: sideset_r[bus.mindex] <= bus.din[4:0];
        ACT_RESTART: restart_r <= bus.din[NUM_SM-1:0];
`ifdef PIO_READBACK_EN
        ACT_READBACK: dout_r <= readback_s;
`endif
        // Idle, imem writes (separate process) and unused codes.
        default: begin
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SM; g++) begin : g_sm
    assign rx_data_s[g]                   = rx_data_flat[32*g +: 32];
    assign instr_flat[16*g +: 16]         = imem_r[pc_flat[IDX_W*g +: IDX_W]];
    assign div_int_flat[16*g +: 16]       = div_int_r[g];
    assign div_frac_flat[8*g +: 8]        = div_frac_r[g];
    assign wrap_top_flat[IDX_W*g +: IDX_W] = wrap_top_r[g];
    assign wrap_tgt_flat[IDX_W*g +: IDX_W] = wrap_tgt_r[g];
    assign pins_flat[32*g +: 32]          = pins_r[g];
    assign sideset_flat[5*g +: 5]         = sideset_r[g];
  end

  assign en       = en_r;
  assign restart  = restart_r;
  assign tx_push  = tx_push_r;
  assign rx_pop   = rx_pop_r;
  assign tx_data  = tx_data_r;
  assign bus.dout = dout_r;

endmodule
